// File: rtl/character_anim_ctrl.sv
// Animation/motion controller for one character: turns key levels and hit pulses
// into the renderer's state code, sprite frame index and per-tick motion strobes.
module character_anim_ctrl #(
  parameter int TICKS_PER_FRAME  = 4,
  parameter int STAND_FRAMES     = 8,
  parameter int ATTACK_FRAMES    = 9,
  parameter int MOVER_FRAMES     = 5,
  parameter int MOVEL_FRAMES     = 5,
  parameter int HURT_FRAMES      = 4,
  parameter int DEFEND_FRAMES    = 1,
  parameter int ATTACK_HIT_FRAME = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hurt_in,
  output logic [7:0] character1_state,
  output logic [7:0] frame_num,
  output logic       move_r1,
  output logic       move_l1,
  output logic       hurt,
  output logic       attack_hit,
  output logic       blocked
);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_ATTACK = 3'd1,
    ST_MOVEL  = 3'd2,
    ST_MOVER  = 3'd3,
    ST_HURT   = 3'd4,
    ST_DEFEND = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(TICKS_PER_FRAME - 1);
  localparam logic [7:0] HIT_IDX  = 8'(ATTACK_HIT_FRAME);

  logic       r_fsync1;
  logic       r_fsync2;
  logic       r_fprev;
  logic       r_tick;
  logic [7:0] r_div;
  logic       r_hurtPend;
  state_t     r_state;
  logic [7:0] r_frame;

  state_t     w_next;
  logic       w_step;
  logic       w_hurtNew;
  logic       w_pend;
  logic       w_lastFrame;
  logic [7:0] w_frameNext;

  function automatic logic [7:0] lastFrameOf(input state_t s);
    case (s)
      ST_STAND:  return 8'(STAND_FRAMES - 1);
      ST_ATTACK: return 8'(ATTACK_FRAMES - 1);
      ST_MOVEL:  return 8'(MOVEL_FRAMES - 1);
      ST_MOVER:  return 8'(MOVER_FRAMES - 1);
      ST_HURT:   return 8'(HURT_FRAMES - 1);
      ST_DEFEND: return 8'(DEFEND_FRAMES - 1);
      default:   return 8'd0;
    endcase
  endfunction

  assign w_step      = r_tick && (r_div == DIV_LAST);
  // A hit arriving on the step cycle itself must count toward that step's decision.
  assign w_hurtNew   = hurt_in && (r_state != ST_HURT) && (r_state != ST_DEFEND);
  assign w_pend      = r_hurtPend | w_hurtNew;
  assign w_lastFrame = (r_frame == lastFrameOf(r_state));
  assign w_frameNext = w_lastFrame ? 8'd0 : r_frame + 8'd1;

  always_comb begin
    w_next = ST_STAND;
    if (w_pend && (r_state != ST_DEFEND))
      w_next = ST_HURT;
    else if ((r_state == ST_ATTACK) || (r_state == ST_HURT))
      w_next = w_lastFrame ? ST_STAND : r_state;
    else if (key_defend)
      w_next = ST_DEFEND;
    else if (key_attack)
      w_next = ST_ATTACK;
    else if (key_right && !key_left)
      w_next = ST_MOVER;
    else if (key_left && !key_right)
      w_next = ST_MOVEL;
    else
      w_next = ST_STAND;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fsync1   <= 1'b0;
      r_fsync2   <= 1'b0;
      r_fprev    <= 1'b0;
      r_tick     <= 1'b0;
      r_div      <= 8'd0;
      r_hurtPend <= 1'b0;
      r_state    <= ST_STAND;
      r_frame    <= 8'd0;
      move_r1    <= 1'b0;
      move_l1    <= 1'b0;
      hurt       <= 1'b0;
      attack_hit <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      r_fsync1 <= frame_clk;
      r_fsync2 <= r_fsync1;
      r_fprev  <= r_fsync2;
      r_tick   <= r_fsync2 & ~r_fprev;

      move_r1    <= r_tick && (r_state == ST_MOVER);
      move_l1    <= r_tick && (r_state == ST_MOVEL);
      hurt       <= r_tick && (r_state == ST_HURT);
      blocked    <= hurt_in && (r_state == ST_DEFEND);
      attack_hit <= 1'b0;

      if (r_tick)
        r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;

      // Hits landing while already hurt are discarded (invulnerability window).
      if (r_state == ST_HURT)
        r_hurtPend <= 1'b0;
      else
        r_hurtPend <= w_pend;

      if (w_step) begin
        if (w_next != r_state) begin
          r_state <= w_next;
          r_frame <= 8'd0;
          r_div   <= 8'd0;
        end else begin
          r_frame <= w_frameNext;
          if ((r_state == ST_ATTACK) && (w_frameNext == HIT_IDX))
            attack_hit <= 1'b1;
        end
        if ((w_next == ST_HURT) || (r_state == ST_DEFEND))
          r_hurtPend <= 1'b0;
      end
    end
  end

  assign character1_state = {5'd0, r_state};
  assign frame_num        = r_frame;

endmodule
